// File: rtl/bcd_conv_pkg.sv
// ============================================================================
// bcd_conv_pkg -- shared types, constants and elaboration helpers for the
//                 iterative binary-to-BCD converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_conv_pkg;

  typedef enum logic {IDLE, CONVERT} bcd_state_t;

  localparam int BCD_DIGIT_W       = 4;
  localparam int BCD_ADJ_THRESHOLD = 5;

  function automatic int bcd_cnt_width(input int n_bits);
    return (n_bits > 1) ? $clog2(n_bits) : 1;
  endfunction

  // True when N decimal digits can hold the largest N_BITS-bit unsigned value.
  function automatic bit bcd_digits_fit(input int n_bits, input int n_digits);
    longint unsigned pow10;
    longint unsigned max_v;
    if (n_bits < 1 || n_bits > 60) return 1'b0;
    pow10 = 64'd1;
    max_v = (64'd1 << n_bits) - 64'd1;
    for (int i = 0; i < n_digits; i++) begin
      if (pow10 > max_v) break;
      pow10 = pow10 * 64'd10;
    end
    return pow10 > max_v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// bcd_digit_adjust -- one BCD digit of the double-dabble correction step:
//                     adds 3 when the digit is 5 or more, no carry out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  localparam logic [BCD_DIGIT_W-1:0] C_THRESH = BCD_DIGIT_W'(BCD_ADJ_THRESHOLD);
  localparam logic [BCD_DIGIT_W-1:0] C_ADD3   = BCD_DIGIT_W'(3);

  assign digit_o = (digit_i >= C_THRESH) ? (digit_i + C_ADD3) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bcd_iterative_converter.sv
// ============================================================================
// bcd_iterative_converter -- sequential shift-and-add-3 binary-to-BCD
//                            converter, one input bit per clock, with
//                            leading-zero blanking mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_iterative_converter
  import bcd_conv_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            trigger,
  input  logic [N_BITS-1:0]               in,
  output logic                            idle,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd,
  output logic [N_DIGITS-1:0]             digit_en
);

  localparam int                SCR_W    = BCD_DIGIT_W * N_DIGITS;
  localparam int                CNT_W    = bcd_cnt_width(N_BITS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_BITS - 1);

  generate
    if (!bcd_digits_fit(N_BITS, N_DIGITS)) begin : g_param_check
      $error("bcd_iterative_converter: N_DIGITS too small for N_BITS");
    end
  endgenerate

  bcd_state_t            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SCR_W-1:0]      scratch_q;
  logic [N_BITS-1:0]     shift_q;
  logic [SCR_W-1:0]      bcd_q;
  logic [N_DIGITS-1:0]   digit_en_q;
  logic                  done_q;

  logic [SCR_W-1:0]      adj_d;
  logic [SCR_W-1:0]      scratch_d;
  logic [N_BITS-1:0]     shift_d;
  logic [N_DIGITS-1:0]   digit_en_d;
  logic                  any_nz_d;

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (adj_d[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Correction first, then the joint left shift; the top adjusted bit falls off.
  assign {scratch_d, shift_d} = {adj_d, shift_q} << 1;

  // Blanking mask propagates "some higher digit is nonzero" downwards.
  always_comb begin
    any_nz_d   = 1'b0;
    digit_en_d = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      any_nz_d      = any_nz_d | (scratch_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      digit_en_d[i] = any_nz_d;
    end
    digit_en_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      scratch_q  <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      digit_en_q <= N_DIGITS'(1);
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            shift_q   <= in;
            scratch_q <= '0;
            cnt_q     <= '0;
            state_q   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bcd_q      <= scratch_d;
            digit_en_q <= digit_en_d;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle     = (state_q == IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign digit_en = digit_en_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_iterative_converter.sv
// ============================================================================
// tb_bcd_iterative_converter -- randomized self-checking bench against a
//                               decimal-arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_iterative_converter;

  localparam int N_BITS   = 16;
  localparam int N_DIGITS = 5;

  logic                    clk = 1'b0;
  logic                    resetN;
  logic                    trigger;
  logic [N_BITS-1:0]       in;
  logic                    idle;
  logic                    done;
  logic [4*N_DIGITS-1:0]   bcd;
  logic [N_DIGITS-1:0]     digit_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [4*N_DIGITS-1:0] last_exp = '0;

  bcd_iterative_converter #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .trigger  (trigger),
    .in       (in),
    .idle     (idle),
    .done     (done),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division, not by shifting.
  function automatic logic [4*N_DIGITS-1:0] ref_bcd(input int v);
    logic [4*N_DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [N_DIGITS-1:0] ref_en(input int v);
    logic [N_DIGITS-1:0] e;
    int p;
    p = 1;
    for (int i = 0; i < N_DIGITS; i++) begin
      e[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (idle !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle", 32'(idle), 32'd1);
  endtask

  task automatic convert(input logic [N_BITS-1:0] v, input bit disturb);
    int cyc;
    bit seen;
    wait_idle();
    trigger = 1'b1;
    in      = v;
    @(posedge clk); #1;
    check("accept_idle", 32'(idle), 32'd0);
    trigger = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else check("bcd_hold", 32'(bcd), 32'(last_exp));
      if (disturb && cyc == 3) begin trigger = 1'b1; in = 16'd7; end
      if (disturb && cyc == 7) trigger = 1'b0;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'd16);
    check("bcd", 32'(bcd), 32'(ref_bcd(int'(v))));
    check("digit_en", 32'(digit_en), 32'(ref_en(int'(v))));
    check("idle_at_done", 32'(idle), 32'd1);
    last_exp = ref_bcd(int'(v));
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
    check("bcd_after", 32'(bcd), 32'(last_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int last_done;
    int ndone;

    resetN  = 1'b1;
    trigger = 1'b0;
    in      = '0;
    #2 resetN = 1'b0;
    #1;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;

    convert(16'd0, 1'b0);
    convert(16'd65535, 1'b0);
    convert(16'd1000, 1'b0);
    convert(16'd9, 1'b0);
    convert(16'd4660, 1'b1);

    // Continuous trigger: one accepted conversion every 17 cycles.
    wait_idle();
    trigger   = 1'b1;
    in        = 16'd42;
    last_done = -1;
    ndone     = 0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (last_done >= 0) check("period", 32'(cyc - last_done), 32'd17);
        check("held_bcd_done", 32'(bcd), 32'h00042);
        last_done = cyc;
        ndone++;
      end else if (ndone > 0) begin
        check("held_bcd", 32'(bcd), 32'h00042);
      end
    end
    trigger = 1'b0;
    check("held_dones", 32'(ndone >= 3), 32'd1);
    wait_idle();
    last_exp = 20'h00042;

    // Reset in the middle of a conversion.
    trigger = 1'b1;
    in      = 16'd12345;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (8) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_digit_en", 32'(digit_en), 32'd1);
    last_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    check("bcd_after_rst", 32'(bcd), 32'd0);
    convert(16'd12345, 1'b0);

    for (int i = 0; i < 16; i++) begin
      convert(N_BITS'($urandom_range(0, 65535)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_iterative_converter.md
# bcd_iterative_converter

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") between the display selector and the seven-segment driver in the RPN calculator datapath. It captures the 16-bit value selected for display and converts it iteratively, one bit per clock. It holds the packed BCD result stable for the seven-segment multiplexer and exposes a trigger/idle handshake plus a one-cycle done pulse. It also produces a leading-zero blanking mask, so the display driver can suppress unused high digits.

## Interface
- N_BITS, default 16: width of the binary input.
- N_DIGITS, default 5: number of BCD output digits. Must satisfy 10^N_DIGITS > 2^N_BITS − 1 (checked by elaboration assertion).
- clk  input  1  system clock, all state updates on rising edge.
- resetN  input  1  reset. One clock; reset is asynchronous and active-low.
- trigger  input  1  start request, sampled only while idle is high.
- in  input  N_BITS  unsigned binary value, sampled on the accepting edge only.
- idle  output  1  high when no conversion is in progress (state decode).
- done  output  1  one-cycle pulse, registered, coincident with the bcd update.
- bcd  output  4·N_DIGITS  packed BCD result, digit 0 in bits [3:0], held until the next done.
- digit_en  output  N_DIGITS  bit i high if digit i or any higher digit is nonzero; bit 0 always high.

## Operation
- States: IDLE, CONVERT.
- IDLE:
  - On an edge with trigger=1: load the shift register with in.
  - Clear the BCD scratch register (4·N_DIGITS bits).
  - Clear the bit counter.
  - Go to CONVERT.
  - trigger=0: stay in IDLE.
- CONVERT, each edge:
  - Every scratch digit ≥ 5 gets +3 (4-bit result, no carry between digits).
  - Then {scratch, shift} shifts left by one.
  - Counter increments.
- The counter counts 0..N_BITS−1. On the edge where counter = N_BITS−1:
  - bcd ← post-shift scratch.
  - digit_en ← computed from that value.
  - done ← 1.
  - State ← IDLE.
- done is 0 on every other edge.
- trigger and in are ignored in CONVERT. A change of in mid-conversion does not affect the result.
- digit_en[N_DIGITS−1] = (digit N_DIGITS−1 ≠ 0). digit_en[i] = digit_en[i+1] | (digit i ≠ 0). digit_en[0] forced to 1.
- Reset (asserted at any time, including mid-CONVERT):
  - state=IDLE, idle=1, done=0.
  - bcd=0, digit_en=1 (only bit 0 set).
  - Counter, scratch and shift register cleared.
  - Any in-flight conversion is discarded; no done is issued for it.

## Timing
- Trigger accepted at edge t → idle low from t.
- bcd, digit_en and done=1 update at edge t+N_BITS. idle returns high at the same edge.
- Latency: N_BITS cycles (16 by default). done is high for exactly the one cycle after edge t+N_BITS.
- With trigger held at 1 continuously, the next conversion is accepted at edge t+N_BITS+1. Conversion period is N_BITS+1 cycles (17 by default).
- bcd never shows intermediate values; it changes only on done edges or reset.
- Reset deassertion: the first trigger can be accepted on the first rising edge with resetN=1.

## Structure
- Package bcd_conv_pkg holds:
  - typedef enum logic {IDLE, CONVERT} bcd_state_t.
  - Constants BCD_DIGIT_W = 4 and BCD_ADJ_THRESHOLD = 5.
  - A function for counter width, $clog2(N_BITS).
- Sub-module bcd_digit_adjust: combinational 4-bit add-3-if-≥5 cell, instantiated N_DIGITS times in a generate loop.
- The top module contains the FSM, counter, shift/scratch registers, output registers and digit_en logic.

## Test plan
- Reset, then trigger with in=0: after 16 cycles done pulses once, bcd=0x00000, digit_en=5'b00001, idle high the same edge.
- in=65535 (max): bcd=0x65535, digit_en=5'b11111, exactly 16 cycles from accepting edge to done.
- in=1000 then in=9: bcd=0x01000 with digit_en=5'b01111, then bcd=0x00009 with digit_en=5'b00001. bcd stays stable between done pulses.
- Trigger pulsed and in changed (4660 → 7) during CONVERT: both ignored, result 0x04660, single done.
- trigger held high with in=42: done pulses every 17 cycles, bcd=0x00042 throughout after the first done.
- resetN asserted at cycle 8 of a conversion of 12345: outputs immediately return to idle=1, bcd=0, digit_en=1, and no done follows. A new trigger after release converts correctly.
